// File: rtl/mm_stage.sv
// Memory-access pipeline stage: request/acknowledge handshake with the MMU/bus for
// loads and stores, load-data formatting, and registered write-back outputs.
module mm_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  inst,
    input  logic [1:0]  mem_access_type,
    input  logic [2:0]  mem_access_size,
    input  logic [31:0] mem_access_addr,
    input  logic [31:0] val_input,
    input  logic [4:0]  bypass_reg_addr,
    input  logic        exception_flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byte_en,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] wb_val,
    output logic [4:0]  wb_reg_addr,
    output logic        wb_we,
    output logic        addr_error,
    output logic [31:0] bad_vaddr
);

    localparam logic [1:0] TYPE_R2R = 2'd0;
    localparam logic [1:0] TYPE_M2R = 2'd1;
    localparam logic [1:0] TYPE_R2M = 2'd2;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_LEFT  = 3'd3;
    localparam logic [2:0] SIZE_RIGHT = 3'd4;

    localparam logic [7:0] INST_LBU = 8'h24;
    localparam logic [7:0] INST_LHU = 8'h25;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic        discard;
    logic [7:0]  inst_q;
    logic [2:0]  size_q;
    logic [1:0]  type_q;
    logic [1:0]  a_q;
    logic [31:0] rt_q;
    logic [4:0]  reg_q;
    logic [31:0] rdata_q;

    logic [1:0]  a;
    logic        memop;
    logic        aligned;

    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SIZE_HALF: is_aligned = !lo[0];
            SIZE_WORD: is_aligned = (lo == 2'd0);
            default:   is_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en_f(input logic [2:0] size, input logic [1:0] lo,
                                             input logic store);
        byte_en_f = 4'b1111;
        if (store) begin
            case (size)
                SIZE_BYTE: byte_en_f = 4'b0001 << lo;
                SIZE_HALF: byte_en_f = lo[1] ? 4'b1100 : 4'b0011;
                SIZE_LEFT: case (lo)
                    2'd0:    byte_en_f = 4'b0001;
                    2'd1:    byte_en_f = 4'b0011;
                    2'd2:    byte_en_f = 4'b0111;
                    default: byte_en_f = 4'b1111;
                endcase
                SIZE_RIGHT: case (lo)
                    2'd0:    byte_en_f = 4'b1111;
                    2'd1:    byte_en_f = 4'b1110;
                    2'd2:    byte_en_f = 4'b1100;
                    default: byte_en_f = 4'b1000;
                endcase
                default: byte_en_f = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] size, input logic [1:0] lo,
                                            input logic [31:0] v);
        case (size)
            SIZE_BYTE: wdata_f = {4{v[7:0]}};
            SIZE_HALF: wdata_f = {2{v[15:0]}};
            SIZE_LEFT: case (lo)
                2'd0:    wdata_f = {24'd0, v[31:24]};
                2'd1:    wdata_f = {16'd0, v[31:16]};
                2'd2:    wdata_f = {8'd0, v[31:8]};
                default: wdata_f = v;
            endcase
            SIZE_RIGHT: case (lo)
                2'd0:    wdata_f = v;
                2'd1:    wdata_f = {v[23:0], 8'd0};
                2'd2:    wdata_f = {v[15:0], 16'd0};
                default: wdata_f = {v[7:0], 24'd0};
            endcase
            default: wdata_f = v;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [7:0] op, input logic [2:0] size,
                                           input logic [1:0] lo, input logic [31:0] m,
                                           input logic [31:0] rt);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        case (lo)
            2'd0:    b = m[7:0];
            2'd1:    b = m[15:8];
            2'd2:    b = m[23:16];
            default: b = m[31:24];
        endcase
        h = lo[1] ? m[31:16] : m[15:0];
        ext = 32'sd0;
        case (size)
            SIZE_BYTE: begin
                ext = b;
                load_f = (op == INST_LBU) ? {24'd0, b} : ext;
            end
            SIZE_HALF: begin
                ext = h;
                load_f = (op == INST_LHU) ? {16'd0, h} : ext;
            end
            SIZE_LEFT: case (lo)
                2'd0:    load_f = {m[7:0], rt[23:0]};
                2'd1:    load_f = {m[15:0], rt[15:0]};
                2'd2:    load_f = {m[23:0], rt[7:0]};
                default: load_f = m;
            endcase
            SIZE_RIGHT: case (lo)
                2'd0:    load_f = m;
                2'd1:    load_f = {rt[31:24], m[31:8]};
                2'd2:    load_f = {rt[31:16], m[31:16]};
                default: load_f = {rt[31:8], m[31:24]};
            endcase
            default: load_f = m;
        endcase
    endfunction

    assign a       = mem_access_addr[1:0];
    assign memop   = (mem_access_type != TYPE_R2R);
    assign aligned = is_aligned(mem_access_size, a);

    assign stall = !rst && (((state == IDLE) && in_valid && memop && aligned && !exception_flush)
                            || (state == REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            discard     <= 1'b0;
            inst_q      <= '0;
            size_q      <= '0;
            type_q      <= '0;
            a_q         <= '0;
            rt_q        <= '0;
            reg_q       <= '0;
            rdata_q     <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_byte_en <= '0;
            bus_wdata   <= '0;
            wb_val      <= '0;
            wb_reg_addr <= '0;
            wb_we       <= 1'b0;
            addr_error  <= 1'b0;
            bad_vaddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr_error <= 1'b0;
                    discard    <= 1'b0;
                    if (!memop) begin
                        wb_val      <= val_input;
                        wb_reg_addr <= bypass_reg_addr;
                        wb_we       <= in_valid && (bypass_reg_addr != 5'd0) && !exception_flush;
                    end else if (in_valid && !exception_flush) begin
                        wb_we <= 1'b0;
                        if (!aligned) begin
                            addr_error <= 1'b1;
                            bad_vaddr  <= mem_access_addr;
                        end else begin
                            inst_q      <= inst;
                            size_q      <= mem_access_size;
                            type_q      <= mem_access_type;
                            a_q         <= a;
                            rt_q        <= val_input;
                            reg_q       <= bypass_reg_addr;
                            bus_req     <= 1'b1;
                            bus_we      <= (mem_access_type == TYPE_R2M);
                            bus_addr    <= {mem_access_addr[31:2], 2'b00};
                            bus_byte_en <= byte_en_f(mem_access_size, a,
                                                     mem_access_type == TYPE_R2M);
                            bus_wdata   <= wdata_f(mem_access_size, a, val_input);
                            state       <= REQ;
                        end
                    end else begin
                        wb_we <= 1'b0;
                    end
                end
                REQ: begin
                    if (exception_flush) discard <= 1'b1;
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // A flush arriving in this very cycle must also suppress the write.
                    if (type_q == TYPE_M2R) begin
                        wb_val      <= load_f(inst_q, size_q, a_q, rdata_q, rt_q);
                        wb_reg_addr <= reg_q;
                        wb_we       <= (reg_q != 5'd0) && !discard && !exception_flush;
                    end else begin
                        wb_we <= 1'b0;
                    end
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mm_stage.md
Name: mm_stage

Overview:
- Memory-access pipeline stage (step_mm), directly downstream of the execute stage.
- Consumes the execute stage's result, memory access address, access type, access size and destination register.
- Runs a single-transaction request/acknowledge handshake with the MMU/bus for loads and stores, and formats load data (sign/zero extension, LWL/LWR merge).
- Produces registered write-back outputs and a stall back to the upstream stages.

Parameters:
- None. All widths are fixed by the ISA: 32-bit data and address, 5-bit register index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream presents an instruction this cycle
- inst  in  8  decoded instruction code (`INST_* in defs.v); used for LBU/LHU and LWL/LWR/SWL/SWR selection
- mem_access_type  in  2  `MEM_ACCESS_TYPE_R2R / M2R / R2M
- mem_access_size  in  3  `MEM_ACCESS_LENGTH_BYTE / HALF / WORD / LEFT_WORD / RIGHT_WORD
- mem_access_addr  in  32  virtual byte address
- val_input  in  32  ALU result (R2R), or rt value (loads and stores)
- bypass_reg_addr  in  5  destination register
- exception_flush  in  1  kill the current instruction
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2], 2'b00}
- bus_byte_en  out  4  byte lane enables; bit i covers bits 8i+7:8i
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  transaction complete; rdata valid in the same cycle
- bus_rdata  in  32  read word
- stall  out  1  hold upstream; combinational
- wb_val  out  32  write-back value
- wb_reg_addr  out  5  write-back register
- wb_we  out  1  write-back enable
- addr_error  out  1  one-cycle pulse: misaligned access
- bad_vaddr  out  32  faulting address, valid while addr_error is high

Behaviour:
- Reset (synchronous, dominant over all other inputs): state IDLE; every registered output cleared to 0; stall forced to 0; discard flag cleared.
- Reset during REQ: bus_req drops on the next cycle with no ack wait. The bus must tolerate an abandoned request.
- States: IDLE, REQ, DONE.
- stall = !rst & ((IDLE & in_valid & memop & aligned & !exception_flush) | REQ).
- memop = mem_access_type != R2R.
- Upstream holds all inputs stable while stall is 1.
- IDLE, R2R instruction:
  - At the clock edge, wb_val <= val_input and wb_reg_addr <= bypass_reg_addr.
  - wb_we <= in_valid & (bypass_reg_addr != 0) & !exception_flush.
  - Latency: 1 cycle, no stall.
- IDLE, aligned memop:
  - Latch inst, size, addr, val_input and reg into internal registers.
  - Drive bus_addr, bus_we (R2M), bus_byte_en and bus_wdata; bus_req <= 1; wb_we <= 0; go to REQ.
- REQ:
  - bus_req and all bus outputs stay stable until bus_ack.
  - On bus_ack: capture bus_rdata, bus_req <= 0, go to DONE.
  - No limit on wait cycles.
- DONE:
  - stall = 0.
  - Load: wb_val <= formatted data, wb_reg_addr <= latched reg, wb_we <= (reg != 0) & !discard.
  - Store: wb_we <= 0.
  - Go to IDLE.
  - Zero-wait load: stall high for 2 cycles; write-back registered at the end of cycle 3.
- Alignment (a = addr[1:0]):
  - HALF requires a[0] = 0.
  - WORD requires a = 0.
  - BYTE, LEFT_WORD and RIGHT_WORD are always aligned.
- Misaligned access (in IDLE, not flushed):
  - No bus request, no stall.
  - addr_error <= 1 for one cycle; bad_vaddr <= addr; wb_we <= 0.
- Byte enables:
  - BYTE: 1<<a.
  - HALF: a[1] ? 1100 : 0011.
  - WORD: 1111.
  - SWL: a = 0/1/2/3 -> 0001 / 0011 / 0111 / 1111.
  - SWR: a = 0/1/2/3 -> 1111 / 1110 / 1100 / 1000.
  - Loads: 1111.
- Store data:
  - SB: byte replicated in all 4 lanes.
  - SH: halfword replicated in both halves.
  - SW: val_input.
  - SWL: val_input >> 8*(3-a).
  - SWR: val_input << 8*a.
- Load formatting:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: word unchanged.
  - LWL: a = 0 -> {m[7:0], rt[23:0]}; 1 -> {m[15:0], rt[15:0]}; 2 -> {m[23:0], rt[7:0]}; 3 -> m.
  - LWR: a = 0 -> m; 1 -> {rt[31:24], m[31:8]}; 2 -> {rt[31:16], m[31:16]}; 3 -> {rt[31:8], m[31:24]}.
- exception_flush:
  - In IDLE: input ignored, wb_we <= 0, no bus request, no addr_error.
  - In REQ or DONE: set discard. The handshake is never aborted. DONE writes wb_we = 0. Discard clears on entry to IDLE.
- bus_ack outside REQ: ignored.

Test Plan:
1. R2R: val_input = 0x1234_5678, reg = 5 -> next cycle wb_val = 0x12345678, wb_reg_addr = 5, wb_we = 1, stall never set; same with reg = 0 -> wb_we = 0.
2. LB at addr 0x1003, rdata = 0x80FF_0000, zero-wait ack -> byte_en = 1111, bus_addr = 0x1000, stall high for 2 cycles, wb_val = 0xFFFFFF80; LBU at the same address -> 0x00000080.
3. SH at 0x2002, rt = 0x0000_BEEF, ack after 3 wait cycles -> bus_we = 1, byte_en = 1100, wdata = 0xBEEFBEEF held stable for 4 cycles, wb_we = 0.
4. LWL at 0x3001, rt = 0xAABBCCDD, rdata = 0x11223344 -> wb_val = 0x3344CCDD; LWR at 0x3001 -> 0xAA112233.
5. LW at 0x4002 -> no bus_req, addr_error pulse with bad_vaddr = 0x4002, wb_we = 0, stall = 0.
6. LW issued, exception_flush asserted in REQ, ack 2 cycles later -> bus_req held until ack, wb_we = 0; separately, rst asserted in REQ -> bus_req = 0 and all outputs 0 on the next cycle.
